// File: rtl/branch_target_buffer.sv
// branch_target_buffer
// Fetch-stage branch target buffer and next-PC generator.
// - Direct-mapped target table looked up combinationally on pc_F, combined
//   with the gshare taken bit to form the predicted next fetch PC.
// - The prediction rides a two-stage {valid, npc} pipe (D, E) down to
//   Execute, where it is checked against the resolved outcome; a mismatch
//   raises redirect_E and flushes the in-flight predictions.
// - Taken branches and jumps train the table.
// Optional build macro: BTB_PERF_CNT_EN adds saturating resolve/redirect
// event counters as extra outputs.

module branch_target_buffer #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_BITS   = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] pc_F,
    input  logic        prediction_F,
    output logic [31:0] npc_F,
    output logic        pred_taken_F,
    input  logic        branch_cmd_E,
    input  logic        jump_E,
    input  logic        cmp_result_E,
    input  logic [31:0] pc_E,
    input  logic [31:0] target_E,
    output logic        redirect_E,
    output logic [31:0] redirect_pc_E
`ifdef BTB_PERF_CNT_EN
    ,
    output logic [31:0] perf_resolve_cnt,
    output logic [31:0] perf_redirect_cnt
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;

    // Target table. Only the valid bits need a reset; tag/target/is_jump are
    // qualified by valid and are left uninitialised.
    logic [ENTRIES-1:0]  r_valid;
    logic [ENTRIES-1:0]  r_is_jump;
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [29:0]         r_target [ENTRIES];

    // Prediction metadata pipe: D follows fetch, E lines up with Execute.
    logic        r_d_valid;
    logic [31:0] r_d_npc;
    logic        r_e_valid;
    logic [31:0] r_e_npc;

    logic [INDEX_BITS-1:0] w_idx_F;
    logic [TAG_BITS-1:0]   w_tag_F;
    logic                  w_hit_F;
    logic [31:0]           w_pc_plus4_F;

    logic [INDEX_BITS-1:0] w_idx_E;
    logic [TAG_BITS-1:0]   w_tag_E;
    logic                  w_resolve;
    logic                  w_act_taken;
    logic [31:0]           w_pc_plus4_E;
    logic [31:0]           w_act_npc;
    logic [31:0]           w_pred_npc;
    logic                  w_redirect;
    logic                  w_train;

    // Fetch-side lookup; reads the table as it stood before this edge, so a
    // same-cycle write to the same index is only seen on the next cycle.
    always_comb begin
        w_idx_F      = pc_F[INDEX_BITS+1:2];
        w_tag_F      = pc_F[INDEX_BITS+2 +: TAG_BITS];
        w_pc_plus4_F = pc_F + 32'd4;
        w_hit_F      = r_valid[w_idx_F] && (r_tag[w_idx_F] == w_tag_F);
        pred_taken_F = w_hit_F && (r_is_jump[w_idx_F] || prediction_F);
        npc_F        = pred_taken_F ? {r_target[w_idx_F], 2'b00} : w_pc_plus4_F;
    end

    // Execute-side resolution: compare the carried prediction with the real
    // outcome. An invalid (flushed or never-filled) E slot predicts fall-through.
    always_comb begin
        w_idx_E       = pc_E[INDEX_BITS+1:2];
        w_tag_E       = pc_E[INDEX_BITS+2 +: TAG_BITS];
        w_resolve     = branch_cmd_E | jump_E;
        w_act_taken   = jump_E | cmp_result_E;
        w_pc_plus4_E  = pc_E + 32'd4;
        w_act_npc     = w_act_taken ? target_E : w_pc_plus4_E;
        w_pred_npc    = r_e_valid ? r_e_npc : w_pc_plus4_E;
        w_redirect    = w_resolve && !stall && (w_act_npc != w_pred_npc);
        // Reset discards a write that would otherwise land on this edge.
        w_train       = w_resolve && w_act_taken && !stall && !rst;
        redirect_E    = w_redirect;
        redirect_pc_E = w_act_npc;
    end

    // Metadata pipe: shift when not stalled, flush both slots on a redirect.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_d_valid <= 1'b0;
            r_d_npc   <= 32'd0;
            r_e_valid <= 1'b0;
            r_e_npc   <= 32'd0;
        end else if (!stall) begin
            r_d_valid <= !w_redirect;
            r_d_npc   <= npc_F;
            r_e_valid <= r_d_valid && !w_redirect;
            r_e_npc   <= r_d_npc;
        end
    end

    // Table valid bits: cleared on reset, set by training.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_train) begin
            r_valid[w_idx_E] <= 1'b1;
        end
    end

    // Table payload: a taken branch/jump overwrites whatever shares its index.
    always_ff @(posedge clk) begin
        if (w_train) begin
            r_tag[w_idx_E]     <= w_tag_E;
            r_target[w_idx_E]  <= target_E[31:2];
            r_is_jump[w_idx_E] <= jump_E;
        end
    end

`ifdef BTB_PERF_CNT_EN
    logic [31:0] r_resolve_cnt;
    logic [31:0] r_redirect_cnt;

    // Saturating event counters; frozen by stall like the rest of the block.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resolve_cnt  <= 32'd0;
            r_redirect_cnt <= 32'd0;
        end else begin
            if (w_resolve && !stall && (r_resolve_cnt != 32'hFFFF_FFFF)) begin
                r_resolve_cnt <= r_resolve_cnt + 32'd1;
            end
            if (w_redirect && (r_redirect_cnt != 32'hFFFF_FFFF)) begin
                r_redirect_cnt <= r_redirect_cnt + 32'd1;
            end
        end
    end

    assign perf_resolve_cnt  = r_resolve_cnt;
    assign perf_redirect_cnt = r_redirect_cnt;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// Testbench for branch_target_buffer: directed steps following the block's
// intended use, then a short random phase, all checked against a small
// behavioural model through an expected-value queue, plus literal checks.

module tb_branch_target_buffer;

    localparam int IB = 6;
    localparam int TB = 8;
    localparam int N  = 1 << IB;

    logic        clk = 1'b0;
    logic        rst, stall, prediction_F, branch_cmd_E, jump_E, cmp_result_E;
    logic [31:0] pc_F, pc_E, target_E;
    logic [31:0] npc_F, redirect_pc_E;
    logic        pred_taken_F, redirect_E;
`ifdef BTB_PERF_CNT_EN
    logic [31:0] perf_resolve_cnt, perf_redirect_cnt;
    logic [31:0] m_res_cnt, m_red_cnt;
`endif

    always #5 clk = ~clk;

    branch_target_buffer #(.INDEX_BITS(IB), .TAG_BITS(TB)) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .pc_F(pc_F), .prediction_F(prediction_F),
        .npc_F(npc_F), .pred_taken_F(pred_taken_F),
        .branch_cmd_E(branch_cmd_E), .jump_E(jump_E), .cmp_result_E(cmp_result_E),
        .pc_E(pc_E), .target_E(target_E),
        .redirect_E(redirect_E), .redirect_pc_E(redirect_pc_E)
`ifdef BTB_PERF_CNT_EN
        , .perf_resolve_cnt(perf_resolve_cnt), .perf_redirect_cnt(perf_redirect_cnt)
`endif
    );

    // Behavioural model state
    bit          mv [N];
    bit          mj [N];
    logic [7:0]  mtag [N];
    logic [29:0] mtgt [N];
    bit          md_v, me_v;
    logic [31:0] md_npc, me_npc;

    // Values computed for the current cycle, consumed at the next edge
    logic [31:0] e_npc, e_rpc;
    bit          e_pt, e_red, e_resolve, e_train, c_rst, c_stall, c_jump;
    logic [31:0] c_pce, c_tge;

    typedef struct { string tag; logic [31:0] exp; } exp_t;
    exp_t sbq[$];

    int n_total = 0;
    int n_pass  = 0;

    task automatic chk(input string t, input logic [31:0] o, input logic [31:0] e);
        n_total++;
        assert (o === e) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%h expected=%h", t, o, e);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            mv[i] = 0;
        end
        md_v = 0; me_v = 0; md_npc = 0; me_npc = 0;
`ifdef BTB_PERF_CNT_EN
        m_res_cnt = 0; m_red_cnt = 0;
`endif
    endtask

    // Apply one cycle of inputs, predict outputs, queue and check them.
    task automatic drive(input bit r, input bit s, input logic [31:0] pcf, input bit pf,
                         input bit br, input bit jp, input bit cmp,
                         input logic [31:0] pce, input logic [31:0] tge);
        int          ix;
        bit          hit, act_t;
        logic [31:0] act_npc, pred_npc, o;
        exp_t        x;
        rst = r; stall = s; pc_F = pcf; prediction_F = pf;
        branch_cmd_E = br; jump_E = jp; cmp_result_E = cmp; pc_E = pce; target_E = tge;
        #2;
        ix        = int'(pcf[IB+1:2]);
        hit       = mv[ix] && (mtag[ix] == pcf[IB+2 +: TB]);
        e_pt      = hit && (mj[ix] || pf);
        e_npc     = e_pt ? {mtgt[ix], 2'b00} : pcf + 32'd4;
        e_resolve = br || jp;
        act_t     = jp || cmp;
        act_npc   = act_t ? tge : pce + 32'd4;
        pred_npc  = me_v ? me_npc : pce + 32'd4;
        e_red     = e_resolve && !s && (act_npc != pred_npc);
        e_rpc     = act_npc;
        e_train   = e_resolve && act_t && !s && !r;
        c_rst = r; c_stall = s; c_jump = jp; c_pce = pce; c_tge = tge;
        if (!r) begin
            sbq.push_back('{"npc_F", e_npc});
            sbq.push_back('{"pred_taken_F", {31'd0, e_pt}});
            sbq.push_back('{"redirect_E", {31'd0, e_red}});
            if (e_resolve) sbq.push_back('{"redirect_pc_E", e_rpc});
`ifdef BTB_PERF_CNT_EN
            sbq.push_back('{"perf_resolve_cnt", m_res_cnt});
            sbq.push_back('{"perf_redirect_cnt", m_red_cnt});
`endif
            while (sbq.size() > 0) begin
                x = sbq.pop_front();
                case (x.tag)
                    "npc_F":         o = npc_F;
                    "pred_taken_F":  o = {31'd0, pred_taken_F};
                    "redirect_E":    o = {31'd0, redirect_E};
                    "redirect_pc_E": o = redirect_pc_E;
`ifdef BTB_PERF_CNT_EN
                    "perf_resolve_cnt":  o = perf_resolve_cnt;
                    "perf_redirect_cnt": o = perf_redirect_cnt;
`endif
                    default:         o = 32'hxxxx_xxxx;
                endcase
                chk(x.tag, o, x.exp);
            end
        end
    endtask

    // Advance one clock and update the model with the values from drive().
    task automatic tick();
        int ix;
        @(posedge clk);
        if (c_rst) begin
            model_reset();
        end else begin
            if (!c_stall) begin
                me_v   = md_v && !e_red;
                me_npc = md_npc;
                md_v   = !e_red;
                md_npc = e_npc;
            end
`ifdef BTB_PERF_CNT_EN
            if (e_resolve && !c_stall && m_res_cnt != 32'hFFFF_FFFF) m_res_cnt++;
            if (e_red && m_red_cnt != 32'hFFFF_FFFF) m_red_cnt++;
`endif
            if (e_train) begin
                ix       = int'(c_pce[IB+1:2]);
                mv[ix]   = 1;
                mtag[ix] = c_pce[IB+2 +: TB];
                mtgt[ix] = c_tge[31:2];
                mj[ix]   = c_jump;
            end
        end
        #1;
    endtask

    initial begin
        logic [31:0] pcs [6];
        pcs[0] = 32'h100; pcs[1] = 32'h200; pcs[2] = 32'h40;
        pcs[3] = 32'h80;  pcs[4] = 32'h1000; pcs[5] = 32'h140;
        model_reset();

        drive(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0); tick();
        drive(1, 0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0); tick();

        // Empty table after reset
        drive(0, 0, 32'h100, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("reset_npc", npc_F, 32'h104);
        chk("reset_pt", {31'd0, pred_taken_F}, 32'd0);
        chk("reset_redirect", {31'd0, redirect_E}, 32'd0);
        tick();

        // Taken branch 0x100->0x200 with empty table: redirect and train
        drive(0, 0, 32'h500, 0, 1, 0, 1, 32'h100, 32'h200);
        chk("first_taken_redirect", {31'd0, redirect_E}, 32'd1);
        chk("first_taken_rpc", redirect_pc_E, 32'h200);
        tick();
        // Trained hit; not-taken resolve right after a flush must not redirect
        drive(0, 0, 32'h100, 1, 1, 0, 0, 32'h600, 32'h0);
        chk("hit_taken_npc", npc_F, 32'h200);
        chk("flushE_no_redirect", {31'd0, redirect_E}, 32'd0);
        tick();
        drive(0, 0, 32'h100, 0, 1, 0, 0, 32'h700, 32'h0);
        chk("hit_nottaken_npc", npc_F, 32'h104);
        chk("flushD_no_redirect", {31'd0, redirect_E}, 32'd0);
        tick();
        // Predicted-taken 0x100 resolves not taken
        drive(0, 0, 32'h40, 0, 1, 0, 0, 32'h100, 32'h200);
        chk("nt_mispredict_redirect", {31'd0, redirect_E}, 32'd1);
        chk("nt_mispredict_rpc", redirect_pc_E, 32'h104);
        tick();
        drive(0, 0, 32'h100, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("entry_unchanged_npc", npc_F, 32'h200);
        tick();

        // JAL 0x40 -> 0x80
        drive(0, 0, 32'h300, 0, 0, 1, 0, 32'h40, 32'h80); tick();
        drive(0, 0, 32'h40, 0, 0, 0, 0, 32'h0, 32'h0);
        chk("jal_pt", {31'd0, pred_taken_F}, 32'd1);
        chk("jal_npc", npc_F, 32'h80);
        tick();
        drive(0, 0, 32'h80, 0, 0, 0, 0, 32'h0, 32'h0); tick();
        drive(0, 0, 32'h84, 0, 0, 1, 0, 32'h40, 32'h80);
        chk("jal_correct_no_redirect", {31'd0, redirect_E}, 32'd0);
        tick();

        // Aliasing: 0x200 shares index 0 with 0x100
        drive(0, 0, 32'h900, 0, 1, 0, 1, 32'h100 + (32'd1 << (IB + 2)), 32'h300); tick();
        drive(0, 0, 32'h100, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("alias_miss_npc", npc_F, 32'h104);
        tick();
        drive(0, 0, 32'h200, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("alias_new_npc", npc_F, 32'h300);
        tick();

        // Stall held across a mispredicting resolve
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'h1000, 1, 1, 0, 1, 32'h1000, 32'h2000);
            chk("stall_no_redirect", {31'd0, redirect_E}, 32'd0);
            chk("stall_no_write_npc", npc_F, 32'h1004);
            tick();
        end
        drive(0, 0, 32'h1000, 1, 1, 0, 1, 32'h1000, 32'h2000);
        chk("post_stall_redirect", {31'd0, redirect_E}, 32'd1);
        chk("post_stall_rpc", redirect_pc_E, 32'h2000);
        chk("same_idx_write_old_npc", npc_F, 32'h1004);
        tick();
        drive(0, 0, 32'h1000, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("after_write_npc", npc_F, 32'h2000);
        chk("redirect_once", {31'd0, redirect_E}, 32'd0);
        tick();

        // Reset mid-operation discards a pending write and clears the table
        drive(1, 0, 32'h0, 0, 1, 0, 1, 32'h3000, 32'h4000); tick();
        drive(0, 0, 32'h3000, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("reset_discard_npc", npc_F, 32'h3004);
        chk("reset_discard_pt", {31'd0, pred_taken_F}, 32'd0);
        tick();
        drive(0, 0, 32'h200, 1, 0, 0, 0, 32'h0, 32'h0);
        chk("reset_clears_npc", npc_F, 32'h204);
        tick();

        // Random mix checked against the model
        for (int i = 0; i < 200; i++) begin
            drive(0, ($urandom_range(0, 3) == 0),
                  pcs[$urandom_range(0, 5)], 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                  1'($urandom_range(0, 1)),
                  pcs[$urandom_range(0, 5)], pcs[$urandom_range(0, 5)] + 32'h40);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
